// File: rtl/tl_pkg.sv
// -----------------------------------------------------------------------------
// tl_pkg
// Shared transaction-layer types for the TX path.
//   tl_stream_t : one beat of a TLP stream (payload + start/end of packet marks)
//   tl_class_e  : traffic class of a queue head (posted / non-posted / completion)
//   tc_next     : next class in the cyclic order posted -> NP -> CPL -> posted
// -----------------------------------------------------------------------------
package tl_pkg;

    localparam int TL_DATA_W = 32;

    typedef struct packed {
        logic [TL_DATA_W-1:0] data;
        logic                 sop;
        logic                 eop;
    } tl_stream_t;

    typedef enum logic [1:0] {
        TC_POSTED = 2'd0,
        TC_NP     = 2'd1,
        TC_CPL    = 2'd2
    } tl_class_e;

    function automatic logic [1:0] tc_next(input logic [1:0] cls);
        return (cls == 2'd2) ? 2'd0 : cls + 2'd1;
    endfunction

endpackage

// File: rtl/tl_tx_out_reg.sv
// -----------------------------------------------------------------------------
// tl_tx_out_reg
// Single-entry valid/ready register stage. Accepts a new beat whenever it is
// empty or its current beat is being drained in the same cycle, so it sustains
// one beat per cycle. Output data/valid hold while stalled.
//   clk, rst_n   : clock, async active-low reset
//   in_data_i    : beat to load          in_valid_i : load request
//   in_ready_o   : stage can accept a beat this cycle
//   out_data_o   : registered beat       out_valid_o: register holds a beat
//   out_ready_i  : downstream accepts the registered beat
// -----------------------------------------------------------------------------
module tl_tx_out_reg
    import tl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  tl_stream_t in_data_i,
    input  logic       in_valid_i,
    output logic       in_ready_o,
    output tl_stream_t out_data_o,
    output logic       out_valid_o,
    input  logic       out_ready_i
);

    tl_stream_t r_data;
    logic       r_valid;

    assign in_ready_o  = ~r_valid | out_ready_i;
    assign out_data_o  = r_data;
    assign out_valid_o = r_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (in_valid_i && in_ready_o) begin
            r_data  <= in_data_i;
            r_valid <= 1'b1;
        end else if (out_ready_i) begin
            r_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/tl_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tl_tx_arbiter
// Arbitrates the posted, non-posted and completion queue heads onto a single
// registered TLP stream toward the link layer. A class may start a packet only
// with an SOP head beat and flow-control credit; once a multi-beat packet
// starts, the arbiter locks onto that class until its EOP beat transfers.
//   CPL_STRICT_PRIO : 1 = eligible completions always win, 0 = round-robin
//   clk, rst_n      : clock, async active-low reset
//   pkt_<cls>_i / pkt_<cls>_valid_i / pkt_<cls>_ready_o : class head streams
//   fc_<cls>_ok_i   : credit available for that class's head packet
//   pkt_o / pkt_valid_o / pkt_ready_i : arbitrated, registered output stream
//   grant_o         : class of current / last granted packet (0 P, 1 NP, 2 CPL)
// -----------------------------------------------------------------------------
module tl_tx_arbiter
    import tl_pkg::*;
#(
    parameter bit CPL_STRICT_PRIO = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  tl_stream_t pkt_posted_i,
    input  logic       pkt_posted_valid_i,
    output logic       pkt_posted_ready_o,
    input  tl_stream_t pkt_np_i,
    input  logic       pkt_np_valid_i,
    output logic       pkt_np_ready_o,
    input  tl_stream_t pkt_cpl_i,
    input  logic       pkt_cpl_valid_i,
    output logic       pkt_cpl_ready_o,
    input  logic       fc_posted_ok_i,
    input  logic       fc_np_ok_i,
    input  logic       fc_cpl_ok_i,
    output tl_stream_t pkt_o,
    output logic       pkt_valid_o,
    input  logic       pkt_ready_i,
    output logic [1:0] grant_o
);

    localparam logic ST_IDLE   = 1'b0;
    localparam logic ST_LOCKED = 1'b1;

    logic       r_state;
    // Last granted class; doubles as the locked class while in LOCKED.
    logic [1:0] r_last;

    logic [3:0] w_vld;
    logic [3:0] w_elig;
    logic [1:0] w_c1;
    logic [1:0] w_c2;
    logic       w_gnt_vld;
    logic [1:0] w_gnt;
    tl_stream_t w_beat;
    logic       w_beat_vld;
    logic       w_load_ok;
    logic       w_take;
    logic       w_xfer;

    // Bit 3 is padding so a 2-bit class index never falls outside the vector.
    always_comb begin
        w_vld  = {1'b0, pkt_cpl_valid_i, pkt_np_valid_i, pkt_posted_valid_i};
        w_elig = w_vld
               & {1'b0, fc_cpl_ok_i, fc_np_ok_i, fc_posted_ok_i}
               & {1'b0, pkt_cpl_i.sop, pkt_np_i.sop, pkt_posted_i.sop};
    end

    assign w_c1 = tc_next(r_last);
    assign w_c2 = tc_next(w_c1);

    // Search starts just after the last grant, so the last-granted class is
    // considered last.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt     = r_last;
        if (r_state == ST_LOCKED) begin
            w_gnt_vld = 1'b1;
            w_gnt     = r_last;
        end else if (CPL_STRICT_PRIO && w_elig[TC_CPL]) begin
            w_gnt_vld = 1'b1;
            w_gnt     = TC_CPL;
        end else if (w_elig[w_c1]) begin
            w_gnt_vld = 1'b1;
            w_gnt     = w_c1;
        end else if (w_elig[w_c2]) begin
            w_gnt_vld = 1'b1;
            w_gnt     = w_c2;
        end else if (w_elig[r_last]) begin
            w_gnt_vld = 1'b1;
            w_gnt     = r_last;
        end
    end

    always_comb begin
        case (w_gnt)
            2'd1: begin
                w_beat     = pkt_np_i;
                w_beat_vld = pkt_np_valid_i;
            end
            2'd2: begin
                w_beat     = pkt_cpl_i;
                w_beat_vld = pkt_cpl_valid_i;
            end
            default: begin
                w_beat     = pkt_posted_i;
                w_beat_vld = pkt_posted_valid_i;
            end
        endcase
    end

    // rst_n gates the readies so nothing is accepted while reset is held.
    assign w_take = rst_n & w_gnt_vld & w_load_ok;
    assign w_xfer = w_take & w_beat_vld;

    assign pkt_posted_ready_o = w_take & (w_gnt == TC_POSTED);
    assign pkt_np_ready_o     = w_take & (w_gnt == TC_NP);
    assign pkt_cpl_ready_o    = w_take & (w_gnt == TC_CPL);
    assign grant_o            = r_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_last  <= TC_CPL;
        end else if (w_xfer) begin
            if (r_state == ST_IDLE) begin
                r_last <= w_gnt;
                if (!w_beat.eop) begin
                    r_state <= ST_LOCKED;
                end
            end else if (w_beat.eop) begin
                r_state <= ST_IDLE;
            end
        end
    end

    tl_tx_out_reg u_out_reg (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data_i   (w_beat),
        .in_valid_i  (w_xfer),
        .in_ready_o  (w_load_ok),
        .out_data_o  (pkt_o),
        .out_valid_o (pkt_valid_o),
        .out_ready_i (pkt_ready_i)
    );

endmodule

// File: doc/tl_tx_arbiter.md
TL_TX_ARBITER -- requirements
Module: tl_tx_arbiter

Interface
REQ-001 Parameter CPL_STRICT_PRIO, default 0, meaning: 1 gives completions strict priority; 0 uses pure round-robin.
REQ-002 clk  input  1  block clock.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 pkt_posted_i / pkt_posted_valid_i / pkt_posted_ready_o  in/in/out  tl_stream_t/1/1  posted queue head stream.
REQ-005 pkt_np_i / pkt_np_valid_i / pkt_np_ready_o  in/in/out  tl_stream_t/1/1  non-posted queue head stream.
REQ-006 pkt_cpl_i / pkt_cpl_valid_i / pkt_cpl_ready_o  in/in/out  tl_stream_t/1/1  completion queue head stream.
REQ-007 fc_posted_ok_i, fc_np_ok_i, fc_cpl_ok_i  input  1 each  flow control reports sufficient credit for that class's head packet.
REQ-008 pkt_o / pkt_valid_o / pkt_ready_i  out/out/in  tl_stream_t/1/1  arbitrated stream to link layer.
REQ-009 grant_o  output  2  class of the current or last-granted packet (0 posted, 1 NP, 2 CPL).

Function
REQ-010 A beat transfers on a port when valid and ready are both 1 on the same rising clk edge.
REQ-011 FSM states: IDLE (no packet owned) and LOCKED (mid multi-beat packet).
REQ-012 A class is eligible in IDLE only when valid=1, sop=1 and its fc_*_ok_i=1.
REQ-013 A head beat with sop=0 in IDLE is never eligible; its ready stays 0.
REQ-014 With CPL_STRICT_PRIO=0, the grant goes to the first eligible class in cyclic order posted->NP->CPL, starting after the last-granted class.
REQ-015 With CPL_STRICT_PRIO=1, an eligible CPL always wins; otherwise REQ-014 applies.
REQ-016 Grant is decided combinationally in IDLE; the SOP beat transfers in the same cycle.
REQ-017 The round-robin pointer updates only on SOP transfer.
REQ-018 An SOP transfer with eop=0 moves the FSM to LOCKED.
REQ-019 An SOP transfer with eop=1 (single beat) stays in IDLE.
REQ-020 In LOCKED only the locked class may transfer; FC is not re-checked; valid gaps are allowed.
REQ-021 The EOP transfer in LOCKED returns the FSM to IDLE; the next SOP may be granted in the following cycle.
REQ-022 Output is a single registered stage, 1-cycle latency from input transfer to pkt_valid_o.
REQ-023 The output register loads when it is empty or pkt_ready_i=1 (full-throughput pipelining).
REQ-024 The granted class ready_o = (out register empty or pkt_ready_i); all other ready_o = 0.
REQ-025 With no grant, all ready_o = 0.
REQ-026 pkt_o and pkt_valid_o hold stable while pkt_valid_o=1 and pkt_ready_i=0.
REQ-027 fc_*_ok_i deasserting during LOCKED does not abort the packet.
REQ-028 Simultaneous output drain and input load in one cycle sustains 1 beat/cycle with no bubble.

Reset
REQ-029 Asserting rst_n low at any time, including mid-packet, immediately forces state IDLE, pkt_valid_o=0, pkt_o='0, all ready_o=0, grant_o=2, and the RR pointer so posted is first.
REQ-030 A partial packet interrupted by reset is not completed; recovery is upstream's responsibility.

Structure
REQ-031 tl_stream_t and the traffic-class enum (POSTED/NP/CPL) reside in tl_pkg; the FSM state enum is local.
REQ-032 One sub-module, tl_tx_out_reg (single-entry valid/ready register), is natural; the arbiter and FSM stay in the top.

Verification
REQ-033 All three classes post 1-beat SOP+EOP packets every cycle, all FC ok, pkt_ready_i=1 -> output class order P,NP,CPL,P,NP,CPL at 1 beat/cycle after 1-cycle latency.
REQ-034 Posted 4-beat packet granted, NP SOP valid from beat 2 -> NP ready stays 0 until the posted EOP transfers; NP SOP is output immediately after the posted EOP beat.
REQ-035 fc_np_ok_i=0 with only NP valid -> no transfer and pkt_valid_o=0; raise fc_np_ok_i -> NP SOP appears on pkt_o 1 cycle later.
REQ-036 CPL_STRICT_PRIO=1, posted and CPL both continuously valid -> every grant is CPL; posted is granted once CPL valid drops.
REQ-037 pkt_ready_i=0 for 3 cycles mid-packet -> pkt_o stable, granted class ready=0, no beat lost or duplicated after pkt_ready_i returns to 1.
REQ-038 rst_n pulsed low during beat 2 of a 3-beat NP packet -> outputs reset per REQ-029 immediately; after release, first grant is posted when all classes are eligible.
